quadra_stream: RTL

- Streaming front/back end for the combinational quadratic evaluator. It sits directly upstream of it, driving its 24-bit x operand from a registered input stage, and directly downstream, capturing its 25-bit y result into an output FIFO.
- Adds valid/ready handshakes on both sides, fixed two-cycle latency and full backpressure. This lets the evaluator sit in a streaming datapath without combinational paths from input to output.

---
 rtl/quadra_stream.sv | 97 +++++++++
 1 files changed

// File: rtl/quadra_stream.sv
`default_nettype none
// ============================================================================
// Module   : quadra_stream
// Brief    : Valid/ready streaming wrapper around a combinational quadratic
//            evaluator: registered operand stage plus result FIFO.
// Revision : 1.0
// ============================================================================
module quadra_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      in_x,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [23:0]      quad_x,
  input  logic [24:0]      quad_y,
  output logic [24:0]      out_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic             s1_valid_q, s1_valid_d;
  logic [23:0]      quad_x_q,   quad_x_d;
  logic [24:0]      mem_q [DEPTH];
  logic [24:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]    count_q,    count_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_occupancy;

  // Occupancy counts the sample still in stage 1, so a full FIFO can never
  // be overrun even though the push itself is unconditional.
  always_comb begin
    w_occupancy = count_q + CW'(s1_valid_q);
    in_ready    = (w_occupancy < C_DEPTH);
    out_valid   = (count_q != '0);
    out_y       = mem_q[rd_ptr_q];
    quad_x      = quad_x_q;
    done_cnt    = done_cnt_q;
    w_accept    = in_valid && in_ready;
    w_push      = s1_valid_q;
    w_pop       = out_valid && out_ready;
  end

  always_comb begin
    s1_valid_d = w_accept;
    quad_x_d   = w_accept ? in_x : quad_x_q;
    wr_ptr_d   = w_push ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d   = w_pop  ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d    = count_q + CW'(w_push) - CW'(w_pop);
    done_cnt_d = w_pop ? done_cnt_q + CNT_W'(1) : done_cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (w_push) begin
      mem_d[wr_ptr_q] = quad_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      quad_x_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      done_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      quad_x_q   <= quad_x_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      done_cnt_q <= done_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
`default_nettype wire
